// File: rtl/cmp_iter_if.sv
// Handshake and operand bundle between the issue stage (master) and the
// iterative comparator (slave).
interface cmp_iter_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
);
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [OP_W-1:0]  op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             illegal;

    modport master (
        output start, flush, opA, opB, op,
        input  busy, done, result, illegal
    );

    modport slave (
        input  start, flush, opA, opB, op,
        output busy, done, result, illegal
    );
endinterface

// File: rtl/cmp_iter.sv
// Multi-cycle comparator: one CHUNK-bit slice per cycle, MSB slice first.
// Optional macro CMP_EARLY_EXIT_EN finishes on the first differing slice.
module cmp_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int OP_W  = 4
) (
    input logic      clk,
    input logic      reset,
    cmp_iter_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [OP_W-1:0] OP_EQ  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SLT = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SGT = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ULT = OP_W'(3);
    localparam logic [OP_W-1:0] OP_UGT = OP_W'(4);
    localparam logic [OP_W-1:0] OP_NE  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SLE = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SGE = OP_W'(7);
    localparam logic [OP_W-1:0] OP_ULE = OP_W'(8);
    localparam logic [OP_W-1:0] OP_UGE = OP_W'(9);
    localparam logic [OP_W-1:0] OP_LTZ = OP_W'(10);
    localparam logic [OP_W-1:0] OP_GEZ = OP_W'(11);
    localparam logic [OP_W-1:0] OP_GTZ = OP_W'(12);
    localparam logic [OP_W-1:0] OP_LEZ = OP_W'(13);

    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OP_W-1:0]  r_op;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_illegal;

    logic             w_accept;
    logic             w_in_signed;
    logic             w_in_zero;
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [CHUNK-1:0] w_a_sl [N];
    logic [CHUNK-1:0] w_b_sl [N];
    logic [CHUNK-1:0] w_a_cur;
    logic [CHUNK-1:0] w_b_cur;
    logic             w_diff;
    logic             w_slice_gt;
    logic             w_eq_next;
    logic             w_gt_next;
    logic             w_lt_next;
    logic             w_last;
    logic             w_res_bit;
    logic             w_res_illegal;

    // Input-side op decode: which ops need the sign flip and which force B to zero.
    always_comb begin
        w_in_signed = 1'b0;
        w_in_zero   = 1'b0;
        case (bus.op)
            OP_SLT, OP_SGT, OP_SLE, OP_SGE: w_in_signed = 1'b1;
            OP_LTZ, OP_GEZ, OP_GTZ, OP_LEZ: begin
                w_in_signed = 1'b1;
                w_in_zero   = 1'b1;
            end
            default: ;
        endcase
    end

    // Flipping the sign bit of both operands turns a signed compare into an unsigned one.
    assign w_a_in = bus.opA ^ (w_in_signed ? SIGN_MASK : '0);
    assign w_b_in = (w_in_zero ? '0 : bus.opB) ^ (w_in_signed ? SIGN_MASK : '0);

    assign w_accept = (r_state != S_BUSY) && bus.start && !bus.flush;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign w_a_sl[gi] = r_a[gi*CHUNK +: CHUNK];
            assign w_b_sl[gi] = r_b[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign w_a_cur    = w_a_sl[r_cnt];
    assign w_b_cur    = w_b_sl[r_cnt];
    assign w_diff     = (w_a_cur != w_b_cur);
    assign w_slice_gt = (w_a_cur > w_b_cur);

    // Only the first differing slice (most significant) decides the ordering.
    assign w_eq_next = r_eq & ~w_diff;
    assign w_gt_next = r_gt | (r_eq & w_diff & w_slice_gt);
    assign w_lt_next = r_lt | (r_eq & w_diff & ~w_slice_gt);

`ifdef CMP_EARLY_EXIT_EN
    assign w_last = (r_cnt == '0) || (r_eq && w_diff);
`else
    assign w_last = (r_cnt == '0);
`endif

    always_comb begin
        w_res_bit     = 1'b0;
        w_res_illegal = 1'b0;
        case (r_op)
            OP_EQ:                  w_res_bit = w_eq_next;
            OP_NE:                  w_res_bit = ~w_eq_next;
            OP_SLT, OP_ULT, OP_LTZ: w_res_bit = w_lt_next;
            OP_SGT, OP_UGT, OP_GTZ: w_res_bit = w_gt_next;
            OP_SLE, OP_ULE, OP_LEZ: w_res_bit = ~w_gt_next;
            OP_SGE, OP_UGE, OP_GEZ: w_res_bit = ~w_lt_next;
            default:                w_res_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_eq      <= 1'b1;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_state <= S_BUSY;
                        r_a     <= w_a_in;
                        r_b     <= w_b_in;
                        r_op    <= bus.op;
                        r_eq    <= 1'b1;
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_cnt   <= CNT_W'(N - 1);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_eq <= w_eq_next;
                        r_gt <= w_gt_next;
                        r_lt <= w_lt_next;
                        if (w_last) begin
                            r_state   <= S_DONE;
                            r_cnt     <= '0;
                            r_result  <= {{(WIDTH-1){1'b0}}, w_res_bit & ~w_res_illegal};
                            r_illegal <= w_res_illegal;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.busy    = (r_state == S_BUSY);
    assign bus.done    = (r_state == S_DONE);
    assign bus.result  = r_result;
    assign bus.illegal = r_illegal;
endmodule

// File: tb/tb_cmp_iter.sv
// Directed vector bench for cmp_iter (WIDTH=32, CHUNK=8): table of compares
// plus hand-written flush, back-to-back and asynchronous-reset sequences.
module tb_cmp_iter;
    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;
    localparam int NV    = 20;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp_res;
        logic        exp_ill;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;
    vec_t vecs [NV];

    cmp_iter_if #(.WIDTH(WIDTH), .OP_W(4)) bus ();

    cmp_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK), .OP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Expected number of BUSY edges: N, or up to the first differing slice with early exit.
    function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
`ifdef CMP_EARLY_EXIT_EN
        logic [31:0] ta;
        logic [31:0] tb;
        ta = a;
        tb = b;
        if (op >= 4'd10 && op <= 4'd13) tb = 32'h0;
        if (op == 4'd1 || op == 4'd2 || op == 4'd6 || op == 4'd7 || (op >= 4'd10 && op <= 4'd13)) begin
            ta[31] = ~ta[31];
            tb[31] = ~tb[31];
        end
        for (int s = N - 1; s >= 0; s--) begin
            if (ta[s*CHUNK +: CHUNK] != tb[s*CHUNK +: CHUNK]) return N - s;
        end
        return N;
`else
        if (a === 32'hx && b === 32'hx && op === 4'hx) return 0;
        return N;
`endif
    endfunction

    // Called at a negedge; leaves the bench at the negedge where done is seen.
    task automatic run_cmp(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] o, input logic [31:0] er, input logic ei);
        int lat;
        bus.start = 1'b1;
        bus.opA   = a;
        bus.opB   = b;
        bus.op    = o;
        @(negedge clk);
        bus.start = 1'b0;
        bus.opA   = $urandom;
        bus.opB   = $urandom;
        bus.op    = 4'($urandom);
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        $display("vec %0d op=%0d a=%h b=%h -> result=%0h illegal=%b latency=%0d",
                 idx, o, a, b, bus.result, bus.illegal, lat);
        check($sformatf("latency[%0d]", idx), 32'(lat), 32'(exp_latency(a, b, o)));
        check($sformatf("result[%0d]", idx), bus.result, er);
        check($sformatf("illegal[%0d]", idx), 32'(bus.illegal), 32'(ei));
    endtask

    initial begin
        int seen_done;
        n_vec = 0;
        n_bad = 0;

        vecs[0]  = '{32'h1234_5678, 32'h1234_5678, 4'd0,  32'd1, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd1,  32'd1, 1'b0};
        vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd3,  32'd0, 1'b0};
        vecs[3]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd4,  32'd1, 1'b0};
        vecs[4]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd2,  32'd0, 1'b0};
        vecs[5]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd5,  32'd1, 1'b0};
        vecs[6]  = '{32'h8000_0000, 32'hDEAD_BEEF, 4'd10, 32'd1, 1'b0};
        vecs[7]  = '{32'h8000_0000, 32'hDEAD_BEEF, 4'd11, 32'd0, 1'b0};
        vecs[8]  = '{32'h0000_0000, 32'hDEAD_BEEF, 4'd12, 32'd0, 1'b0};
        vecs[9]  = '{32'h0000_0000, 32'hDEAD_BEEF, 4'd13, 32'd1, 1'b0};
        vecs[10] = '{32'h0000_0001, 32'h0000_0001, 4'd6,  32'd1, 1'b0};
        vecs[11] = '{32'h0000_0001, 32'h0000_0001, 4'd7,  32'd1, 1'b0};
        vecs[12] = '{32'h0000_0005, 32'h0000_0003, 4'd8,  32'd0, 1'b0};
        vecs[13] = '{32'h0000_0005, 32'h0000_0003, 4'd9,  32'd1, 1'b0};
        vecs[14] = '{32'h1234_5678, 32'h1234_5679, 4'd0,  32'd0, 1'b0};
        vecs[15] = '{32'h0000_0005, 32'h0000_0003, 4'd15, 32'd0, 1'b1};
        vecs[16] = '{32'h0000_0005, 32'h0000_0003, 4'd2,  32'd1, 1'b0};
        vecs[17] = '{32'h7FFF_FFFF, 32'h8000_0000, 4'd1,  32'd0, 1'b0};
        vecs[18] = '{32'h0000_0001, 32'h0000_0002, 4'd14, 32'd0, 1'b1};
        vecs[19] = '{32'h0100_0000, 32'h0000_0000, 4'd4,  32'd1, 1'b0};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.opA   = '0;
        bus.opB   = '0;
        bus.op    = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",    32'(bus.busy),    32'd0);
        check("reset_done",    32'(bus.done),    32'd0);
        check("reset_result",  bus.result,       32'd0);
        check("reset_illegal", 32'(bus.illegal), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // First vector starts from IDLE; the rest are accepted straight out of DONE.
        for (int i = 0; i < NV; i++) begin
            run_cmp(i, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_res, vecs[i].exp_ill);
        end
        @(negedge clk);
        check("idle_after_done", 32'(bus.busy), 32'd0);

        // Flush on the second BUSY cycle: no done, result keeps 1 from the last vector.
        bus.start = 1'b1;
        bus.opA   = 32'd5;
        bus.opB   = 32'd5;
        bus.op    = 4'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        seen_done = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.done) seen_done = 1;
            @(negedge clk);
        end
        $display("flush sequence: busy=%b result=%0h illegal=%b", bus.busy, bus.result, bus.illegal);
        check("flush_no_done",   32'(seen_done),   32'd0);
        check("flush_result",    bus.result,       32'd1);
        check("flush_illegal",   32'(bus.illegal), 32'd0);

        // Flush wins over start in DONE and in IDLE.
        run_cmp(100, 32'd7, 32'd9, 4'd3, 32'd1, 1'b0);
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.opA   = 32'd1;
        bus.opB   = 32'd1;
        bus.op    = 4'd5;
        @(negedge clk);
        check("flush_done_busy", 32'(bus.busy), 32'd0);
        check("flush_done_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("flush_idle_busy", 32'(bus.busy), 32'd0);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        check("flush_keep_result", bus.result, 32'd1);
        @(negedge clk);

        // Asynchronous reset in the middle of a compare.
        bus.start = 1'b1;
        bus.opA   = 32'd1;
        bus.opB   = 32'd2;
        bus.op    = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        $display("async reset: busy=%b done=%b result=%0h illegal=%b",
                 bus.busy, bus.done, bus.result, bus.illegal);
        check("areset_busy",    32'(bus.busy),    32'd0);
        check("areset_done",    32'(bus.done),    32'd0);
        check("areset_result",  bus.result,       32'd0);
        check("areset_illegal", 32'(bus.illegal), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cmp_iter.md
Name: cmp_iter

Overview:
- Parametrised, multi-cycle successor to the D-stage combinational comparator.
- Compares two WIDTH-bit operands one CHUNK-bit slice per cycle, starting at the MSB slice, so wide compares meet timing.
- Supports signed, unsigned and compare-against-zero operations.
- Returns a zero-extended boolean result through a start/busy/done handshake; the issue stage stalls on busy.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; N = WIDTH/CHUNK slices.
- OP_W, 4, width of the op code.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- start, input, 1, request a compare; accepted only in IDLE or DONE.
- flush, input, 1, synchronous abort of the compare in flight.
- opA, input, WIDTH, operand A; sampled on the accepting edge.
- opB, input, WIDTH, operand B; sampled on the accepting edge.
- op, input, OP_W, operation; sampled on the accepting edge.
- busy, output, 1, high while in BUSY.
- done, output, 1, one-cycle pulse when result becomes valid.
- result, output, WIDTH, 0 or 1 zero-extended; held until the next completed compare.
- illegal, output, 1, latched with result; high if op was undefined.

Behaviour:
- Reset (async, active-high) forces: state=IDLE, busy=0, done=0, result=0, illegal=0, slice counter=0.
- Op codes:
  - 0 eq, 1 slt signed, 2 sgt signed, 3 ult, 4 ugt, 5 ne.
  - 6 sle signed, 7 sge signed, 8 ule, 9 uge.
  - 10 ltz, 11 gez, 12 gtz, 13 lez; all signed A versus 0, with B forced to 0 when latched.
  - 14 and 15 are illegal.
- Signed ops invert bit WIDTH-1 of both latched operands; the compare is then unsigned throughout.
- States:
  - IDLE: start=1 latches A, B and op, clears eq_acc=1 and gt_acc=lt_acc=0, sets counter=N-1, goes to BUSY.
  - BUSY: each edge compares the slice selected by the counter (MSB slice first).
    - If eq_acc is set and the slice differs, set gt_acc or lt_acc and clear eq_acc.
    - Decrement the counter.
    - On the edge that processes counter==0, register result and illegal, then go to DONE.
  - DONE: done=1 for exactly one cycle. Next state is BUSY if start=1 (back-to-back accept, new operands latched), otherwise IDLE.
- Latency: a start accepted at edge k gives done=1 in the cycle after edge k+N. Throughput is one compare per N+1 cycles.
- Result is derived from eq/gt/lt after the final slice. Illegal op gives result=0 and illegal=1.
- start while BUSY is ignored; it is not queued.
- flush in BUSY: go to IDLE next edge, no done pulse, result and illegal unchanged.
- flush in IDLE or DONE: no effect on result; a start in the same cycle is ignored (flush wins).
- Operand inputs may change freely after the accepting edge; only latched copies are used.
- WIDTH==CHUNK (N=1) is legal: one BUSY cycle.

Optional Feature:
- Macro: CMP_EARLY_EXIT_EN.
- Defined: in BUSY, the first slice that differs completes the compare. Result is registered on that edge and the next state is DONE, so latency = (slices processed)+1.
- Not defined: always N BUSY cycles (fixed latency); slices after the first difference leave the accumulators unchanged.

Test Plan (WIDTH=32, CHUNK=8, N=4, early exit off unless noted):
- Equal operands: opA=opB=0x1234_5678, op=0 at edge k → busy high for edges k+1..k+4; done=1 in the cycle after edge k+4; result=0x0000_0001, illegal=0.
- Signed versus unsigned on the same data: opA=0xFFFF_FFFF, opB=0x0000_0001 → op=1 gives result=1; op=3 gives result=0; op=4 gives result=1.
- Zero compares: opA=0x8000_0000 → op=10 (ltz)=1, op=11 (gez)=0. opA=0 → op=12 (gtz)=0, op=13 (lez)=1. opB is ignored (drive 0xDEAD_BEEF).
- Illegal op and back-to-back:
  - op=15 → result=0, illegal=1.
  - start held high in DONE with opA=5, opB=3, op=2 → re-enters BUSY without an IDLE cycle; the next done gives result=1, illegal=0.
- Flush and reset mid-operation:
  - flush on the 2nd BUSY cycle → IDLE, no done, result keeps its previous value.
  - reset pulsed asynchronously mid-BUSY → busy=0, done=0, result=0 immediately.
- CMP_EARLY_EXIT_EN defined: opA=0x0100_0000, opB=0x0000_0000, op=4 → done=1 in the cycle after edge k+1; result=1.
